// File: rtl/gem_cluster_pkg.sv
// rtl/gem_cluster_pkg.sv - shared cluster constants, types and helpers
// Purpose: cluster field widths, frame/FIFO geometry, filler codes, and
//          helpers for address validity and 8-bit population count.
package gem_cluster_pkg;

  localparam int MXCLSTBITS     = 14;
  localparam int MXADRBITS      = 11;
  localparam int MXCNTBITS      = 3;
  localparam int MXPADS         = 1536;
  localparam int MXCLUSTERS     = 8;
  localparam int CLST_PER_FRAME = 4;
  localparam int MXOUTBITS      = CLST_PER_FRAME * MXCLSTBITS;
  localparam int FIFO_DEPTH     = 32;
  localparam int FIFO_AW        = 5;

  typedef logic [MXCLSTBITS-1:0] cluster_t;

  localparam cluster_t CLUSTER_FILLER   = 14'h07FF;
  localparam cluster_t CLUSTER_NOTREADY = 14'h07FE;

  // Addresses 0x600..0x7FF carry no pad (filler / not-ready codes live there).
  function automatic logic cluster_is_valid(input logic [MXADRBITS-1:0] adr);
    return adr < MXADRBITS'(MXPADS);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

endpackage

// File: rtl/cluster_link_framer_if.sv
// rtl/cluster_link_framer_if.sv - packer-to-link cluster/frame bundle
// Purpose: groups the per-bx cluster input and the assembled frame output.
// Ports (signals):
//   clusters_valid, clusters_in[111:0] : packer output, one bx per valid cycle
//   frame_out[55:0], frame_valid       : assembled link frame and its pulse
// Modports: master = cluster source / frame sink, slave = framer.
interface cluster_link_framer_if;
  import gem_cluster_pkg::*;

  logic                             clusters_valid;
  logic [MXCLUSTERS*MXCLSTBITS-1:0] clusters_in;
  logic [MXOUTBITS-1:0]             frame_out;
  logic                             frame_valid;

  modport master (
    output clusters_valid, clusters_in,
    input  frame_out, frame_valid
  );

  modport slave (
    input  clusters_valid, clusters_in,
    output frame_out, frame_valid
  );

endinterface

// File: rtl/cluster_fifo_8w1r.sv
// rtl/cluster_fifo_8w1r.sv - 8-write compacting, 1-read cluster FIFO
// Purpose: writes the masked clusters of one bx to consecutive entries,
//          pops at most one entry per cycle and tracks occupancy.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_mask[7:0]        : per-slot write request (already valid-filtered)
//   wr_data[111:0]      : eight clusters, slot i at [14*i+13:14*i]
//   rd_en               : pop request, ignored when empty
//   rd_data, rd_valid   : head entry and non-empty flag
//   count[5:0]          : occupancy 0..32
//   wr_count[3:0]       : entries actually written this cycle
module cluster_fifo_8w1r
  import gem_cluster_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [MXCLUSTERS-1:0]            wr_mask,
  input  logic [MXCLUSTERS*MXCLSTBITS-1:0] wr_data,
  input  logic                             rd_en,
  output cluster_t                         rd_data,
  output logic                             rd_valid,
  output logic [FIFO_AW:0]                 count,
  output logic [3:0]                       wr_count
);

  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  cluster_t           mem_q [FIFO_DEPTH];

  logic [FIFO_AW:0]   free;
  logic [3:0]         off [MXCLUSTERS];
  logic [MXCLUSTERS-1:0] wr_sel;
  logic [3:0]         run;
  logic               pop;

  // Free space ignores a same-cycle pop, so a full FIFO never accepts a push.
  assign free = (FIFO_AW+1)'(FIFO_DEPTH) - count_q;

  // Prefix sum of the mask gives each valid slot its compacted offset;
  // only the first 'free' valid slots are kept.
  always_comb begin
    run    = 4'd0;
    wr_sel = '0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      off[i]    = run;
      wr_sel[i] = wr_mask[i] && ({2'b00, run} < free);
      run       = run + {3'b000, wr_mask[i]};
    end
  end

  assign wr_count = popcount8(wr_sel);
  assign pop      = rd_en && (count_q != '0);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + FIFO_AW'(wr_count);
      rd_ptr_q <= rd_ptr_q + {{(FIFO_AW-1){1'b0}}, pop};
      count_q  <= count_q + {2'b00, wr_count} - {{FIFO_AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MXCLUSTERS; i++) begin
      if (wr_sel[i]) mem_q[wr_ptr_q + FIFO_AW'(off[i])] <= wr_data[i*MXCLSTBITS +: MXCLSTBITS];
    end
  end

endmodule

// File: rtl/cluster_link_framer.sv
// rtl/cluster_link_framer.sv - drops invalid clusters, buffers, frames 4 per bx
// Purpose: filters packer clusters, queues them, and drains one per clock4x
//          into a 56-bit frame aligned to bx_strobe.
// Ports:
//   clock4x, global_reset_n : 160 MHz clock, asynchronous active-low reset
//   bx_strobe               : frame phase-0 marker
//   clear_counters          : synchronous clear of overflow/dropped_cnt
//   link (slave)            : clusters_valid/clusters_in in, frame_out/frame_valid out
//   locked, fifo_count      : strobe seen since reset, FIFO occupancy
//   overflow, dropped_cnt   : sticky loss flag, saturating loss count
module cluster_link_framer
  import gem_cluster_pkg::*;
(
  input  logic                 clock4x,
  input  logic                 global_reset_n,
  input  logic                 bx_strobe,
  input  logic                 clear_counters,
  cluster_link_framer_if.slave link,
  output logic                 locked,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow,
  output logic [15:0]          dropped_cnt
);

  logic [1:0]           phase_q, phase_d, cur_phase;
  logic                 locked_q, locked_d;
  cluster_t             slot_q [3];
  cluster_t             slot_d [3];
  logic [2:0]           real_q, real_d;
  logic [MXOUTBITS-1:0] frame_q, frame_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          dropped_q, dropped_d;

  logic [MXCLUSTERS-1:0] mask;
  logic                  active, popped, misaligned;
  cluster_t              rd_data, pop_cl;
  logic                  rd_valid;
  logic [3:0]            wr_count, excess;
  logic [1:0]            lost;
  logic [4:0]            drops;
  logic [16:0]           sum;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MXCLUSTERS; i++)
      mask[i] = link.clusters_valid && cluster_is_valid(link.clusters_in[i*MXCLSTBITS +: MXADRBITS]);
  end

  // Reading starts in the very cycle of the first strobe.
  assign active = locked_q || bx_strobe;

  cluster_fifo_8w1r u_fifo (
    .clk      (clock4x),
    .rst_n    (global_reset_n),
    .wr_mask  (mask),
    .wr_data  (link.clusters_in),
    .rd_en    (active),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .wr_count (wr_count)
  );

  always_comb begin
    cur_phase     = bx_strobe ? 2'd0 : phase_q;
    phase_d       = cur_phase + 2'd1;
    locked_d      = locked_q || bx_strobe;
    slot_d        = slot_q;
    real_d        = real_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    popped        = active && rd_valid;
    pop_cl        = popped ? rd_data : CLUSTER_FILLER;

    // A strobe while phase_q != 0 cuts a frame short; real clusters already
    // placed in slots below phase_q are lost with it.
    misaligned = bx_strobe && locked_q && (phase_q != 2'd0);
    lost       = 2'd0;
    for (int j = 0; j < 3; j++)
      if (misaligned && (2'(j) < phase_q) && real_q[j]) lost = lost + 2'd1;

    if (active) begin
      case (cur_phase)
        2'd0: begin slot_d[0] = pop_cl; real_d[0] = popped; end
        2'd1: begin slot_d[1] = pop_cl; real_d[1] = popped; end
        2'd2: begin slot_d[2] = pop_cl; real_d[2] = popped; end
        default: begin
          frame_d       = {pop_cl, slot_q[2], slot_q[1], slot_q[0]};
          frame_valid_d = 1'b1;
        end
      endcase
    end

    excess = popcount8(mask) - wr_count;
    drops  = {1'b0, excess} + {3'b000, lost};
    sum    = {1'b0, dropped_q} + {12'b0, drops};
    dropped_d  = sum[16] ? 16'hFFFF : sum[15:0];
    overflow_d = overflow_q || (drops != 5'd0);
    if (clear_counters) begin
      dropped_d  = 16'd0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      phase_q       <= 2'd0;
      locked_q      <= 1'b0;
      for (int j = 0; j < 3; j++) slot_q[j] <= CLUSTER_FILLER;
      real_q        <= 3'b000;
      frame_q       <= {CLST_PER_FRAME{CLUSTER_FILLER}};
      frame_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      dropped_q     <= 16'd0;
    end else begin
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      slot_q        <= slot_d;
      real_q        <= real_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overflow_q    <= overflow_d;
      dropped_q     <= dropped_d;
    end
  end

  assign link.frame_out   = frame_q;
  assign link.frame_valid = frame_valid_q;
  assign locked           = locked_q;
  assign overflow         = overflow_q;
  assign dropped_cnt      = dropped_q;

endmodule
